// File: rtl/fp_add_align_stage2.sv
// FP adder stage 2: restores hidden bits and iteratively right-aligns the smaller mantissa.
// Optional sticky accumulation is enabled with `define FP_ALIGN_STICKY_EN.

// state | meaning
// IDLE  | ready for operands; latches them on in_valid
// SHIFT | shifting the smaller mantissa right by up to SHIFT_STEP bits per cycle
// DONE  | result valid; held until out_ready
module fp_add_align_stage2 #(
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8,
  parameter int SHIFT_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXPO_WIDTH:0]   exp_diff_in,
  input  logic [MENT_WIDTH-1:0] smaller_operand_in,
  input  logic [MENT_WIDTH-1:0] bigger_operand_in,
  input  logic [EXPO_WIDTH-1:0] bigger_exponent_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MENT_WIDTH+2:0] aligned_mant_out,
  output logic                  sticky_out,
  output logic [MENT_WIDTH:0]   bigger_mant_out,
  output logic [EXPO_WIDTH-1:0] bigger_exponent_out
);

  localparam int W  = MENT_WIDTH + 3;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          work_q, work_d;
  logic [CW-1:0]         rem_q, rem_d;
  logic [MENT_WIDTH:0]   big_mant_q, big_mant_d;
  logic [EXPO_WIDTH-1:0] big_exp_q, big_exp_d;

  logic [EXPO_WIDTH:0]   diff_mag;
  logic [CW-1:0]         amt;
  logic [EXPO_WIDTH-1:0] small_exp;
  logic                  hidden_s;
  logic                  hidden_b;
  logic [CW-1:0]         step;
  logic                  accept;

  // -256 negates to itself, which reads correctly as an unsigned magnitude of 256
  assign diff_mag  = exp_diff_in[EXPO_WIDTH] ? -exp_diff_in : exp_diff_in;
  assign amt       = (int'(diff_mag) > W) ? CW'(W) : diff_mag[CW-1:0];
  assign small_exp = bigger_exponent_in - diff_mag[EXPO_WIDTH-1:0];
  assign hidden_s  = (small_exp != '0);
  assign hidden_b  = (bigger_exponent_in != '0);
  assign step      = (rem_q > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : rem_q;
  assign accept    = (state_q == IDLE) && in_valid;

  assign in_ready            = (state_q == IDLE);
  assign out_valid           = (state_q == DONE);
  assign aligned_mant_out    = work_q;
  assign bigger_mant_out     = big_mant_q;
  assign bigger_exponent_out = big_exp_q;

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    rem_d      = rem_q;
    big_mant_d = big_mant_q;
    big_exp_d  = big_exp_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d     = {hidden_s, smaller_operand_in, 2'b00};
          rem_d      = amt;
          big_mant_d = {hidden_b, bigger_operand_in};
          big_exp_d  = bigger_exponent_in;
          state_d    = (amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        work_d = work_q >> step;
        rem_d  = rem_q - step;
        if (rem_q == step) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      work_q     <= '0;
      rem_q      <= '0;
      big_mant_q <= '0;
      big_exp_q  <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      rem_q      <= rem_d;
      big_mant_q <= big_mant_d;
      big_exp_q  <= big_exp_d;
    end
  end

`ifdef FP_ALIGN_STICKY_EN
  logic         sticky_q;
  logic [W-1:0] lost_mask;

  // bits falling off the bottom of the work register this cycle
  assign lost_mask = ~({W{1'b1}} << step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (accept) begin
      sticky_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      sticky_q <= sticky_q | (|(work_q & lost_mask));
    end
  end

  assign sticky_out = sticky_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign sticky_out    = 1'b0;
`endif

endmodule

// File: tb/tb_fp_add_align_stage2.sv
// Directed self-checking bench for fp_add_align_stage2 (default parameters).
module tb_fp_add_align_stage2;

`ifdef FP_ALIGN_STICKY_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  exp_diff_in;
  logic [22:0] smaller_operand_in;
  logic [22:0] bigger_operand_in;
  logic [7:0]  bigger_exponent_in;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] aligned_mant_out;
  logic        sticky_out;
  logic [23:0] bigger_mant_out;
  logic [7:0]  bigger_exponent_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0]  d;
    logic [22:0] sm;
    logic [22:0] bm;
    logic [7:0]  be;
    int          lat;
    logic [25:0] am;
    logic        st;
    logic [23:0] bmo;
  } vec_t;

  fp_add_align_stage2 dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .exp_diff_in         (exp_diff_in),
    .smaller_operand_in  (smaller_operand_in),
    .bigger_operand_in   (bigger_operand_in),
    .bigger_exponent_in  (bigger_exponent_in),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .aligned_mant_out    (aligned_mant_out),
    .sticky_out          (sticky_out),
    .bigger_mant_out     (bigger_mant_out),
    .bigger_exponent_out (bigger_exponent_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Caller sits 1 unit after a rising edge with the DUT in IDLE.
  // Returns cycles from the accept edge to out_valid (20 means it never arrived).
  task automatic start_op(input logic [8:0] d, input logic [22:0] sm, input logic [22:0] bm,
                          input logic [7:0] be, output int lat);
    exp_diff_in        = d;
    smaller_operand_in = sm;
    bigger_operand_in  = bm;
    bigger_exponent_in = be;
    in_valid           = 1'b1;
    @(posedge clk); #1;
    in_valid           = 1'b0;
    exp_diff_in        = 9'h0AA;
    smaller_operand_in = 23'h5A5A5A;
    bigger_operand_in  = 23'h2B2B2B;
    bigger_exponent_in = 8'hEE;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (aligned_mant_out !== 26'h0) begin errors++; $display("FAIL reset_aligned got %h want 0", aligned_mant_out); end
    checks++; if (sticky_out !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", sticky_out); end
    checks++; if (bigger_mant_out !== 24'h0) begin errors++; $display("FAIL reset_bigger_mant got %h want 0", bigger_mant_out); end
    checks++; if (bigger_exponent_out !== 8'h0) begin errors++; $display("FAIL reset_bigger_exp got %h want 0", bigger_exponent_out); end
  endtask

  task automatic test_vectors();
    vec_t v[8];
    int   lat;
    v[0] = '{9'h003, 23'h000000, 23'h400000, 8'h82, 2, 26'h0400000, 1'b0, 24'hC00000};
    v[1] = '{9'h1FB, 23'h00001F, 23'h000000, 8'h85, 3, 26'h0100003, SEN,  24'h800000};
    v[2] = '{9'h028, 23'h000001, 23'h000000, 8'hA0, 8, 26'h0000000, SEN,  24'h800000};
    v[3] = '{9'h000, 23'h123456, 23'h654321, 8'h00, 1, 26'h048D158, 1'b0, 24'h654321};
    v[4] = '{9'h100, 23'h7FFFFF, 23'h000001, 8'h10, 8, 26'h0000000, SEN,  24'h800001};
    v[5] = '{9'h004, 23'h000003, 23'h7FFFFF, 8'h10, 2, 26'h0200000, SEN,  24'hFFFFFF};
    v[6] = '{9'h1FE, 23'h000004, 23'h000000, 8'h02, 2, 26'h0000004, 1'b0, 24'h800000};
    v[7] = '{9'h008, 23'h0000FF, 23'h7FFFFF, 8'h09, 3, 26'h0020003, SEN,  24'hFFFFFF};
    for (int i = 0; i < 8; i++) begin
      start_op(v[i].d, v[i].sm, v[i].bm, v[i].be, lat);
      checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, v[i].lat); end
      checks++; if (aligned_mant_out !== v[i].am) begin errors++; $display("FAIL vec%0d_aligned got %h want %h", i, aligned_mant_out, v[i].am); end
      checks++; if (sticky_out !== v[i].st) begin errors++; $display("FAIL vec%0d_sticky got %b want %b", i, sticky_out, v[i].st); end
      checks++; if (bigger_mant_out !== v[i].bmo) begin errors++; $display("FAIL vec%0d_bigger_mant got %h want %h", i, bigger_mant_out, v[i].bmo); end
      checks++; if (bigger_exponent_out !== v[i].be) begin errors++; $display("FAIL vec%0d_bigger_exp got %h want %h", i, bigger_exponent_out, v[i].be); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_valid_drop got %b want 0", i, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_ready_back got %b want 1", i, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(9'h003, 23'h000000, 23'h400000, 8'h82, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL bp_latency got %0d want 2", lat); end
    // offer new operands while stalled; they must not be taken
    exp_diff_in        = 9'h000;
    smaller_operand_in = 23'h111111;
    bigger_exponent_in = 8'h33;
    in_valid           = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc%0d got %b want 1", c, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got %b want 0", c, in_ready); end
      checks++; if (aligned_mant_out !== 26'h0400000) begin errors++; $display("FAIL bp_aligned cyc%0d got %h want 0400000", c, aligned_mant_out); end
      checks++; if (bigger_exponent_out !== 8'h82) begin errors++; $display("FAIL bp_bigger_exp cyc%0d got %h want 82", c, bigger_exponent_out); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    start_op(9'h000, 23'h123456, 23'h654321, 8'h00, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL bp_next_latency got %0d want 1", lat); end
    checks++; if (aligned_mant_out !== 26'h048D158) begin errors++; $display("FAIL bp_next_aligned got %h want 048d158", aligned_mant_out); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    exp_diff_in        = 9'h028;
    smaller_operand_in = 23'h000001;
    bigger_operand_in  = 23'h000000;
    bigger_exponent_in = 8'hA0;
    in_valid           = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
    checks++; if (aligned_mant_out !== 26'h0) begin errors++; $display("FAIL rst_mid_aligned got %h want 0", aligned_mant_out); end
    checks++; if (sticky_out !== 1'b0) begin errors++; $display("FAIL rst_mid_sticky got %b want 0", sticky_out); end
    checks++; if (bigger_mant_out !== 24'h0) begin errors++; $display("FAIL rst_mid_bigger_mant got %h want 0", bigger_mant_out); end
    checks++; if (bigger_exponent_out !== 8'h0) begin errors++; $display("FAIL rst_mid_bigger_exp got %h want 0", bigger_exponent_out); end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_after_valid got %b want 0", out_valid); end
    start_op(9'h1FB, 23'h00001F, 23'h000000, 8'h85, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rst_fresh_latency got %0d want 3", lat); end
    checks++; if (aligned_mant_out !== 26'h0100003) begin errors++; $display("FAIL rst_fresh_aligned got %h want 0100003", aligned_mant_out); end
    checks++; if (sticky_out !== SEN) begin errors++; $display("FAIL rst_fresh_sticky got %b want %b", sticky_out, SEN); end
    checks++; if (bigger_mant_out !== 24'h800000) begin errors++; $display("FAIL rst_fresh_bigger_mant got %h want 800000", bigger_mant_out); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n              = 1'b0;
    in_valid           = 1'b0;
    out_ready          = 1'b0;
    exp_diff_in        = '0;
    smaller_operand_in = '0;
    bigger_operand_in  = '0;
    bigger_exponent_in = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_vectors();
    test_backpressure();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
